// File: rtl/per_slave_rr_arbiter.sv
// -----------------------------------------------------------------------------
// per_slave_rr_arbiter
//
// Shares one peripheral slave port between N_MASTER requesters. It sits on the
// slave side of the peripheral interconnect, after the per-master address
// decoders.
//
// Arbitration is round-robin, and grants are returned in the same cycle. Every
// accepted transaction records the originating master index in an in-order
// FIFO. The slave returns responses in order, so each response goes to the
// master at the FIFO head. The FIFO depth, MAX_OUTSTANDING, caps the number of
// outstanding transactions.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   data_req_i      request per master
//   data_add_i      per-master address, master i at slice i
//   data_wen_i      per-master wen (1 = read, 0 = write)
//   data_wdata_i    per-master write data
//   data_be_i       per-master byte enables
//   data_gnt_o      one-hot grant, combinational from per_gnt_i
//   data_r_valid_o  one-hot response valid, routed to the FIFO head master
//   data_r_rdata_o  response data, broadcast to all masters
//   data_r_opc_o    response error, broadcast to all masters
//   per_req_o       slave request (any request and FIFO not full)
//   per_add_o       address of the winning master
//   per_wen_o       wen of the winning master
//   per_wdata_o     write data of the winning master
//   per_be_o        byte enables of the winning master
//   per_gnt_i       slave grant
//   per_r_valid_i   slave response valid (responses arrive in order)
//   per_r_rdata_i   slave read data
//   per_r_opc_i     slave error
//   err_o           sticky flag: a response arrived with no transaction outstanding
// -----------------------------------------------------------------------------
module per_slave_rr_arbiter #(
  parameter int N_MASTER        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTER-1:0]            data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_MASTER-1:0]            data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
  output logic [N_MASTER-1:0]            data_gnt_o,
  output logic [N_MASTER-1:0]            data_r_valid_o,
  output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
  output logic                           data_r_opc_o,
  output logic                           per_req_o,
  output logic [ADDR_WIDTH-1:0]          per_add_o,
  output logic                           per_wen_o,
  output logic [DATA_WIDTH-1:0]          per_wdata_o,
  output logic [BE_WIDTH-1:0]            per_be_o,
  input  logic                           per_gnt_i,
  input  logic                           per_r_valid_i,
  input  logic [DATA_WIDTH-1:0]          per_r_rdata_i,
  input  logic                           per_r_opc_i,
  output logic                           err_o
);

  localparam int unsigned NM    = unsigned'(N_MASTER);
  localparam int          IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int          PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int          CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTER - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(MAX_OUTSTANDING);

  // Arbitration state
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             any_req;

  // Outstanding FIFO of master indices
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] head;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign any_req = |data_req_i;
  assign head    = fifo_q[rd_ptr];

  assign per_req_o = any_req && !full;
  assign push      = per_req_o && per_gnt_i;
  assign pop       = per_r_valid_i && !empty;

  // Response data and error go to every master without gating. Only the
  // one-hot valid tells a master that the response is its own.
  assign data_r_rdata_o = per_r_rdata_i;
  assign data_r_opc_o   = per_r_opc_i;

  // ---------------------------------------------------------------------------
  // Round-robin search. Masters are checked in order from rr_ptr, wrapping at
  // N_MASTER-1, so N_MASTER need not be a power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    winner = rr_ptr;
    cand   = rr_ptr;
    found  = 1'b0;
    for (int unsigned k = 0; k < NM; k++) begin
      if (!found && data_req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Request fields from the winner, and the zero-latency grant. Every field is
  // forced to zero while no request is issued, either because no master is
  // requesting or because the FIFO is full.
  // ---------------------------------------------------------------------------
  always_comb begin
    per_add_o   = '0;
    per_wen_o   = 1'b0;
    per_wdata_o = '0;
    per_be_o    = '0;
    data_gnt_o  = '0;
    for (int unsigned m = 0; m < NM; m++) begin
      if (per_req_o && (winner == IDX_W'(m))) begin
        per_add_o     = data_add_i[m*ADDR_WIDTH +: ADDR_WIDTH];
        per_wen_o     = data_wen_i[m];
        per_wdata_o   = data_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
        per_be_o      = data_be_i[m*BE_WIDTH +: BE_WIDTH];
        data_gnt_o[m] = per_gnt_i;
      end
    end
  end

  // Route the response to the master recorded at the FIFO head.
  always_comb begin
    data_r_valid_o = '0;
    for (int unsigned m = 0; m < NM; m++) begin
      if (pop && (head == IDX_W'(m))) begin
        data_r_valid_o[m] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Priority pointer. It moves only on a handshake. A stalled winner keeps
  // priority until the slave grants it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
    end
  end

  // The FIFO storage has no reset. An entry is read only after it has been
  // written, because count gates every pop.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (per_r_valid_i && empty) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_per_slave_rr_arbiter.sv
module tb_per_slave_rr_arbiter;

  localparam int NM   = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     data_req_i;
  logic [NM*AW-1:0]  data_add_i;
  logic [NM-1:0]     data_wen_i;
  logic [NM*DW-1:0]  data_wdata_i;
  logic [NM*BW-1:0]  data_be_i;
  logic [NM-1:0]     data_gnt_o;
  logic [NM-1:0]     data_r_valid_o;
  logic [DW-1:0]     data_r_rdata_o;
  logic              data_r_opc_o;
  logic              per_req_o;
  logic [AW-1:0]     per_add_o;
  logic              per_wen_o;
  logic [DW-1:0]     per_wdata_o;
  logic [BW-1:0]     per_be_o;
  logic              per_gnt_i;
  logic              per_r_valid_i;
  logic [DW-1:0]     per_r_rdata_i;
  logic              per_r_opc_i;
  logic              err_o;

  per_slave_rr_arbiter #(
    .N_MASTER(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
    .data_r_opc_o(data_r_opc_o), .per_req_o(per_req_o), .per_add_o(per_add_o),
    .per_wen_o(per_wen_o), .per_wdata_o(per_wdata_o), .per_be_o(per_be_o),
    .per_gnt_i(per_gnt_i), .per_r_valid_i(per_r_valid_i),
    .per_r_rdata_i(per_r_rdata_i), .per_r_opc_i(per_r_opc_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        opc;
    logic        exp_preq;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_rv;
    logic        exp_err;
  } vec_t;

  logic [AW-1:0] addr_tab  [NM];
  logic [DW-1:0] wdata_tab [NM];
  logic [BW-1:0] be_tab    [NM];
  logic          wen_tab   [NM];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sb[$];
  int   m_rr;
  logic m_err;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] req, input logic g,
                              input logic rv, input logic [31:0] rd, input logic opc,
                              input logic ep, input logic [3:0] eg, input logic [3:0] erv,
                              input logic ee);
    vec_t v;
    v.rst = r; v.req = req; v.gnt = g; v.rv = rv; v.rdata = rd; v.opc = opc;
    v.exp_preq = ep; v.exp_gnt = eg; v.exp_rv = erv; v.exp_err = ee;
    return v;
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int start);
    for (int k = 0; k < NM; k++) begin
      int idx;
      idx = (start + k) % NM;
      if (((r >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check at the falling edge, then advance the reference model.
  task automatic apply(input vec_t v);
    int            w;
    logic          preq, pop, empty_before;
    logic [3:0]    egnt, erv;
    logic [AW-1:0] eadd;
    logic [DW-1:0] ewdata;
    logic [BW-1:0] ebe;
    logic          ewen;
    rst           = v.rst;
    data_req_i    = v.req;
    per_gnt_i     = v.gnt;
    per_r_valid_i = v.rv;
    per_r_rdata_i = v.rdata;
    per_r_opc_i   = v.opc;
    @(negedge clk);
    if (v.rst) begin
      sb.delete();
      m_rr  = 0;
      m_err = 1'b0;
    end else begin
      w            = rr_pick(v.req, m_rr);
      preq         = (v.req != 4'd0) && (sb.size() < MAXO);
      empty_before = (sb.size() == 0);
      pop          = v.rv && !empty_before;
      egnt         = (preq && v.gnt) ? 4'(1 << w) : 4'd0;
      erv          = pop ? 4'(1 << sb[0]) : 4'd0;
      eadd = '0; ewdata = '0; ebe = '0; ewen = 1'b0;
      if (preq) begin
        eadd = addr_tab[w]; ewdata = wdata_tab[w]; ebe = be_tab[w]; ewen = wen_tab[w];
      end
      chk("tbl_per_req", 32'(per_req_o), 32'(v.exp_preq));
      chk("tbl_gnt", 32'(data_gnt_o), 32'(v.exp_gnt));
      chk("tbl_rvalid", 32'(data_r_valid_o), 32'(v.exp_rv));
      chk("tbl_err", 32'(err_o), 32'(v.exp_err));
      chk("mdl_gnt", 32'(data_gnt_o), 32'(egnt));
      chk("per_add", per_add_o, eadd);
      chk("per_wen", 32'(per_wen_o), 32'(ewen));
      chk("per_wdata", per_wdata_o, ewdata);
      chk("per_be", 32'(per_be_o), 32'(ebe));
      chk("sb_rvalid", 32'(data_r_valid_o), 32'(erv));
      if (pop) begin
        chk("sb_rdata", data_r_rdata_o, v.rdata);
        chk("sb_opc", 32'(data_r_opc_o), 32'(v.opc));
        void'(sb.pop_front());
      end
      chk("mdl_err", 32'(err_o), 32'(m_err));
      if (v.rv && empty_before) m_err = 1'b1;
      if (preq && v.gnt) begin
        sb.push_back(w);
        m_rr = (w + 1) % NM;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    addr_tab[0] = 32'h1A10_0010; addr_tab[1] = 32'h1A10_0020;
    addr_tab[2] = 32'h1A10_0004; addr_tab[3] = 32'h1A10_0030;
    for (int i = 0; i < NM; i++) begin
      wdata_tab[i] = 32'hC0DE_0000 | 32'(i);
      be_tab[i]    = BW'(1 << i);
      wen_tab[i]   = (i % 2) == 1;
      data_add_i[i*AW +: AW]   = addr_tab[i];
      data_wdata_i[i*DW +: DW] = wdata_tab[i];
      data_be_i[i*BW +: BW]    = be_tab[i];
      data_wen_i[i]            = wen_tab[i];
    end
    rst = 1'b1; data_req_i = '0; per_gnt_i = 1'b0; per_r_valid_i = 1'b0;
    per_r_rdata_i = '0; per_r_opc_i = 1'b0;
    m_rr = 0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, single master, then a stalled all-request cycle
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 1, 0, 32'h0,         0, 1, 4'b0100, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 32'hDEADBEEF,  0, 0, 4'b0000, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 32'h0,         0, 1, 4'b0000, 4'b0000, 0));
    // Fairness: four continuous requesters, immediate responses
    vecs.push_back(mk(1, 4'b0000, 0, 0, 32'h0,         0, 0, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 32'h0,         0, 1, 4'b0001, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 1, 32'h0000_1000, 0, 1, 4'b0010, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 1, 32'h0000_1001, 0, 1, 4'b0100, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 1, 32'h0000_1002, 1, 1, 4'b1000, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 1, 32'h0000_1003, 0, 1, 4'b0001, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 32'h0000_1004, 0, 0, 4'b0000, 4'b0001, 0));
    // Back-pressure: masters 1 and 3, slave stalls three cycles
    vecs.push_back(mk(0, 4'b1010, 0, 0, 32'h0,         0, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1010, 0, 0, 32'h0,         0, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1010, 0, 0, 32'h0,         0, 1, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1010, 1, 0, 32'h0,         0, 1, 4'b0010, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1010, 1, 0, 32'h0,         0, 1, 4'b1000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 32'h0000_2001, 0, 0, 4'b0000, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 32'h0000_2003, 1, 0, 4'b0000, 4'b1000, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Full FIFO: four handshakes, block, one response, resume, drain
    apply(mk(1, 4'b0000, 0, 0, 32'h0, 0, 0, 4'b0000, 4'b0000, 0));
    apply(mk(0, 4'b1111, 1, 0, 32'h0, 0, 1, 4'b0001, 4'b0000, 0));
    apply(mk(0, 4'b1111, 1, 0, 32'h0, 0, 1, 4'b0010, 4'b0000, 0));
    apply(mk(0, 4'b1111, 1, 0, 32'h0, 0, 1, 4'b0100, 4'b0000, 0));
    apply(mk(0, 4'b1111, 1, 0, 32'h0, 0, 1, 4'b1000, 4'b0000, 0));
    apply(mk(0, 4'b1111, 1, 0, 32'h0, 0, 0, 4'b0000, 4'b0000, 0));
    apply(mk(0, 4'b1111, 1, 0, 32'h0, 0, 0, 4'b0000, 4'b0000, 0));
    apply(mk(0, 4'b1111, 1, 1, 32'hAAAA_0001, 0, 0, 4'b0000, 4'b0001, 0));
    apply(mk(0, 4'b1111, 1, 0, 32'h0, 0, 1, 4'b0001, 4'b0000, 0));
    apply(mk(0, 4'b0000, 0, 1, 32'hAAAA_0002, 0, 0, 4'b0000, 4'b0010, 0));
    apply(mk(0, 4'b0000, 0, 1, 32'hAAAA_0003, 1, 0, 4'b0000, 4'b0100, 0));
    apply(mk(0, 4'b0000, 0, 1, 32'hAAAA_0004, 0, 0, 4'b0000, 4'b1000, 0));
    apply(mk(0, 4'b0000, 0, 1, 32'hAAAA_0005, 0, 0, 4'b0000, 4'b0001, 0));

    // Simultaneous push and pop at count 2, then an empty response error
    apply(mk(1, 4'b0000, 0, 0, 32'h0, 0, 0, 4'b0000, 4'b0000, 0));
    apply(mk(0, 4'b0001, 1, 0, 32'h0, 0, 1, 4'b0001, 4'b0000, 0));
    apply(mk(0, 4'b0010, 1, 0, 32'h0, 0, 1, 4'b0010, 4'b0000, 0));
    apply(mk(0, 4'b0100, 1, 1, 32'h1111_0000, 1, 1, 4'b0100, 4'b0001, 0));
    apply(mk(0, 4'b0000, 0, 1, 32'h2222_0000, 0, 0, 4'b0000, 4'b0010, 0));
    apply(mk(0, 4'b0000, 0, 1, 32'h3333_0000, 0, 0, 4'b0000, 4'b0100, 0));
    apply(mk(0, 4'b0000, 0, 1, 32'h4444_0000, 0, 0, 4'b0000, 4'b0000, 0));
    apply(mk(0, 4'b0000, 0, 0, 32'h0, 0, 0, 4'b0000, 4'b0000, 1));
    apply(mk(0, 4'b0000, 0, 0, 32'h0, 0, 0, 4'b0000, 4'b0000, 1));
    apply(mk(0, 4'b0001, 1, 0, 32'h0, 0, 1, 4'b0001, 4'b0000, 1));
    apply(mk(0, 4'b0000, 0, 1, 32'h5555_0000, 0, 0, 4'b0000, 4'b0001, 1));
    apply(mk(1, 4'b0000, 0, 0, 32'h0, 0, 0, 4'b0000, 4'b0000, 0));
    apply(mk(0, 4'b0000, 0, 0, 32'h0, 0, 0, 4'b0000, 4'b0000, 0));

    // Reset with one transaction outstanding discards it
    apply(mk(0, 4'b1000, 1, 0, 32'h0, 0, 1, 4'b1000, 4'b0000, 0));
    apply(mk(1, 4'b0000, 0, 0, 32'h0, 0, 0, 4'b0000, 4'b0000, 0));
    apply(mk(0, 4'b0000, 0, 1, 32'h6666_0000, 0, 0, 4'b0000, 4'b0000, 0));
    apply(mk(0, 4'b0000, 0, 0, 32'h0, 0, 0, 4'b0000, 4'b0000, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
